// File: rtl/sram_uart_bridge.sv
// Byte-stream command decoder: turns rx command/address/data bytes into
// single-port SRAM write/read strobes and streams read words back on tx.
module sram_uart_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data_out,
  input  logic              rx_valid,
  output logic              rx_enable,
  output logic              rx_ready,
  input  logic              tx_ready,
  output logic              tx_enable,
  output logic              tx_valid,
  output logic [7:0]        tx_data_in,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              err_pulse
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int BC_W       = $clog2(DATA_BYTES + 2);
  localparam int TM_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [BC_W-1:0]  DB_LAST  = BC_W'(DATA_BYTES - 1);
  localparam logic [BC_W-1:0]  AB_LAST  = BC_W'(ADDR_BYTES - 1);
  localparam logic [TM_W-1:0]  TM_LAST  = (TIMEOUT == 0) ? '0 : TM_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RSEND} state_t;

  state_t            state, state_next;
  logic              cmd_rd;
  logic [7:0]        count;
  logic [ADDR_W-1:0] addr_q;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] wbuf, rbuf;
  logic [TM_W-1:0]   timer;
  logic [LAT_W-1:0]  lat_cnt;
  logic              tx_valid_q, err_q, rx_ready_q;
  logic [7:0]        tx_data_q;
  logic              rx_fire, tx_fire, timeout_hit, in_rx_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    rx_fire     = rx_valid && rx_ready_q;
    tx_fire     = tx_valid_q && tx_ready;
    in_rx_phase = (state == ADDR) || (state == WDATA);
    timeout_hit = (TIMEOUT != 0) && in_rx_phase && !rx_fire && (timer == TM_LAST);
    state_next  = state;
    case (state)
      IDLE:  if (rx_fire) state_next = ADDR;
      ADDR:  begin
        if (timeout_hit)                         state_next = IDLE;
        else if (rx_fire && byte_cnt == AB_LAST) state_next = cmd_rd ? RREQ : WDATA;
      end
      WDATA: begin
        if (timeout_hit)                         state_next = IDLE;
        else if (rx_fire && byte_cnt == DB_LAST) state_next = WRITE;
      end
      WRITE: state_next = (count == 8'd1) ? IDLE : WDATA;
      RREQ:  state_next = RWAIT;
      RWAIT: if (lat_cnt == LAT_LAST) state_next = RSEND;
      RSEND: if (tx_fire && byte_cnt == DB_LAST) state_next = (count == 8'd1) ? IDLE : RREQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_enable    = rst_n;
    rx_ready     = rx_ready_q;
    tx_enable    = (state == RSEND);
    tx_valid     = tx_valid_q;
    tx_data_in   = tx_data_q;
    csb_n        = !((state == WRITE) || (state == RREQ));
    we_n         = (state != WRITE);
    addr         = addr_q;
    sram_data_in = (state == WRITE) ? wbuf : '0;
    err_pulse    = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rd     <= 1'b0;
      count      <= '0;
      addr_q     <= '0;
      byte_cnt   <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      timer      <= '0;
      lat_cnt    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      err_q      <= timeout_hit;
      rx_ready_q <= (state_next == IDLE) || (state_next == ADDR) || (state_next == WDATA);
      timer      <= (in_rx_phase && !rx_fire && !timeout_hit) ? timer + 1'b1 : '0;
      case (state)
        IDLE: if (rx_fire) begin
          cmd_rd   <= rx_data_out[7];
          count    <= {1'b0, rx_data_out[6:0]} + 8'd1;
          byte_cnt <= '0;
        end
        // Address bytes arrive MSB first; shifting in and truncating drops unused upper bits.
        ADDR: if (rx_fire) begin
          addr_q   <= ADDR_W'({addr_q, rx_data_out});
          byte_cnt <= (byte_cnt == AB_LAST) ? '0 : byte_cnt + 1'b1;
        end
        WDATA: if (rx_fire) begin
          wbuf[byte_cnt*8 +: 8] <= rx_data_out;
          byte_cnt              <= (byte_cnt == DB_LAST) ? '0 : byte_cnt + 1'b1;
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          count  <= count - 8'd1;
        end
        RREQ: lat_cnt <= '0;
        RWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rbuf       <= sram_data_out;
            tx_data_q  <= sram_data_out[7:0];
            tx_valid_q <= 1'b1;
            byte_cnt   <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RSEND: if (tx_fire) begin
          if (byte_cnt == DB_LAST) begin
            tx_valid_q <= 1'b0;
            byte_cnt   <= '0;
            addr_q     <= addr_q + 1'b1;
            count      <= count - 8'd1;
          end else begin
            byte_cnt  <= byte_cnt + 1'b1;
            tx_data_q <= rbuf[(byte_cnt + 1'b1)*8 +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
